pipe_pattern_engine: RTL and testbench
======================================

Name: pipe_pattern_engine

Overview:
Parametrised pattern generator/checker pair for benchmarking and verifying block-throttled PipeOut/PipeIn endpoints. It generalises the fixed-32-bit pipe checkers in four ways: configurable data width, selectable pattern modes, block-granular ready generation, and first-error capture. It sits between the host interface pipe endpoints and the wire-in control registers. It runs entirely in the host interface clock domain.

Parameters:
DATA_WIDTH, 32, pipe word width; multiple of 32, range 32..128; LANES = DATA_WIDTH/32.
BLOCK_WORDS, 256, words per ready-granted block; power of 2, ≥2.
ERR_WIDTH, 32, error counter width.

Ports:
clk  in  1  host interface clock; all logic on rising edge.
reset_n  in  1  synchronous, active-low reset.
mode  in  3  pattern select; sampled while reset_n=0 only.
seed  in  32  fixed value or LFSR seed; sampled while reset_n=0 only.
throttle_set  in  1  loads throttle_val into throttle register.
throttle_val  in  32  throttle pattern.
gen_read  in  1  PipeOut read strobe.
gen_data  out  DATA_WIDTH  current generated word.
gen_ready  out  1  PipeOut block ready.
chk_write  in  1  PipeIn write strobe.
chk_data  in  DATA_WIDTH  received word.
chk_ready  out  1  PipeIn block ready.
error_count  out  ERR_WIDTH  saturating mismatch count.
first_err_valid  out  1  sticky; a mismatch has occurred.
first_err_index  out  32  checker word index of the first mismatch.
word_count  out  32  words checked; wraps modulo 2^32.

Behaviour:
- Reset (reset_n=0 at edge):
  - gen_ready=0, chk_ready=0, error_count=0, first_err_valid=0, first_err_index=0, word_count=0.
  - Throttle register = 0xFFFFFFFF.
  - gen and chk word indices = 0; gen_data = word 0 of the selected pattern.
  - LFSR state = seed; if seed==0, LFSR state = 0x00000001.
- Reset mid-block: all of the above applies at that edge. Strobes seen during reset are ignored.
- Patterns, word index n, lane k (lane k = bits [32k+31:32k]), all arithmetic mod 2^32:
  - mode 0, counter: n*LANES+k.
  - mode 1, LFSR: Fibonacci LFSR, taps 32,22,2,1. Lane k = state after n*LANES+k steps. The LFSR advances LANES steps per word.
  - mode 2, walking ones: 1 << ((n*LANES+k) mod 32).
  - mode 3, fixed: seed in every lane.
  - mode 4, alternating: seed for even n, ~seed for odd n.
  - modes 5–7: treated as mode 0.
- Generator:
  - gen_data is registered.
  - On a cycle with gen_read=1, gen_data shows word n+1 from the next edge (one-cycle advance).
- Checker:
  - The checker keeps an independent expected-word generator of identical construction.
  - On chk_write=1, chk_data is compared with the expected word n; the index then advances.
  - error_count and word_count update at the following edge (1-cycle latency).
  - error_count saturates at all-ones.
  - On the first mismatch, first_err_index=n and first_err_valid=1. Both hold until reset.
- Throttle:
  - The throttle register rotates left by 1 every cycle.
  - throttle_set=1 loads throttle_val instead of rotating, and takes priority over rotation.
  - The throttle MSB (bit 31) is the grant bit.
- Block ready. gen and chk each have an independent ready FSM with states IDLE, ACTIVE, GAP:
  - IDLE → ACTIVE when grant bit=1; ready=1 from the next edge.
  - ACTIVE: count strobes. After the BLOCK_WORDS-th strobe, go to GAP; ready=0 at the following edge.
  - GAP → IDLE after exactly 1 cycle; ready is guaranteed low for ≥1 cycle between blocks.
- Strobe while ready=0: the word is still consumed or checked and the index still advances. The strobe does not affect the block count.
- Simultaneous events:
  - gen_read and chk_write in the same cycle are independent.
  - throttle_set and a grant in the same cycle: the loaded value takes effect from the next cycle.

Optional Feature:
PIPE_PATTERN_INJECT_EN
- Defined: adds input port inject_err (1 bit). A 1-cycle pulse arms a flag. The next word presented after a gen_read has lane 0 bit 0 inverted, then the flag clears. Multiple pulses before that read arm a single injection.
- Undefined: the port is absent; gen_data is always the pure pattern.

Test Plan:
1. DATA_WIDTH=64, mode 0, throttle left at reset value, read 3 words → gen_data = 0x00000001_00000000, 0x00000003_00000002, 0x00000005_00000004.
2. Mode 1, seed 0, generator looped into checker for 1024 words → error_count=0, word_count=1024, first_err_valid=0.
3. Mode 3, seed 0xA5A5A5A5, corrupt checker words 5 and 9 → error_count=2, first_err_index=5, first_err_valid=1.
4. BLOCK_WORDS=4, throttle_set with 0x80000000, continuous reads → gen_ready high for exactly 4 cycles, starting one cycle after each grant, i.e. once per 32-cycle rotation.
5. ERR_WIDTH=4, 20 mismatching writes → error_count saturates at 0xF.
6. reset_n low for 1 cycle mid-block in mode 0 → gen_ready=0 at the next edge, gen_data returns to word 0, and error_count, first_err_valid, first_err_index and word_count all return to 0.

Source files
------------

// File: rtl/pipe_pattern_engine.sv
// Pattern generator/checker pair for throttled PipeOut/PipeIn endpoints with block-granular ready.
// Optional error injection on the generator is enabled by defining PIPE_PATTERN_INJECT_EN.

module pipe_pattern_ready_fsm #(
    parameter int BLOCK_WORDS = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       grant,
    input  logic       strobe,
    output logic       ready,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_GAP = 2'd2} state_t;
    localparam int CW = $clog2(BLOCK_WORDS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:   if (grant) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                // Only strobes seen while ready is high count toward the block.
                if (strobe) begin
                    if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    assign ready     = (state_q == ST_ACTIVE);
    assign state_dbg = state_q;
endmodule

module pipe_pattern_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 256,
    parameter int ERR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            mode,
    input  logic [31:0]           seed,
    input  logic                  throttle_set,
    input  logic [31:0]           throttle_val,
    input  logic                  gen_read,
`ifdef PIPE_PATTERN_INJECT_EN
    input  logic                  inject_err,
`endif
    output logic [DATA_WIDTH-1:0] gen_data,
    output logic                  gen_ready,
    input  logic                  chk_write,
    input  logic [DATA_WIDTH-1:0] chk_data,
    output logic                  chk_ready,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic                  first_err_valid,
    output logic [31:0]           first_err_index,
    output logic [31:0]           word_count,
    output logic [1:0]            gen_state_dbg,
    output logic [1:0]            chk_state_dbg
);
    localparam int          LANES   = DATA_WIDTH / 32;
    localparam logic [31:0] LANES_W = 32'(LANES);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < LANES; i++) r = lfsr_step(r);
        return r;
    endfunction

    // lfsr holds the state for lane 0 of word n; later lanes step from there.
    function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [2:0] m, input logic [31:0] s,
                                                           input logic [31:0] n, input logic [31:0] lfsr);
        logic [DATA_WIDTH-1:0] w;
        logic [31:0]           st;
        logic [31:0]           pos;
        w  = '0;
        st = lfsr;
        for (int k = 0; k < LANES; k++) begin
            pos = n * LANES_W + 32'(k);
            case (m)
                3'd1:    w[32*k +: 32] = st;
                3'd2:    w[32*k +: 32] = 32'd1 << pos[4:0];
                3'd3:    w[32*k +: 32] = s;
                3'd4:    w[32*k +: 32] = n[0] ? ~s : s;
                default: w[32*k +: 32] = pos;
            endcase
            st = lfsr_step(st);
        end
        return w;
    endfunction

    logic [2:0]            mode_q;
    logic [31:0]           seed_q;
    logic [31:0]           gen_idx_q, gen_idx_d, gen_lfsr_q, gen_lfsr_d;
    logic [DATA_WIDTH-1:0] gen_data_q, gen_data_d;
    logic [31:0]           chk_idx_q, chk_idx_d, chk_lfsr_q, chk_lfsr_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  first_valid_q, first_valid_d;
    logic [31:0]           first_idx_q, first_idx_d;
    logic [31:0]           wc_q, wc_d;
    logic [31:0]           thr_q, thr_d;
    logic [31:0]           lfsr_init;
    logic [DATA_WIDTH-1:0] rst_word;
    logic [DATA_WIDTH-1:0] chk_exp;
`ifdef PIPE_PATTERN_INJECT_EN
    logic                  inj_q, inj_d;
`endif

    assign lfsr_init = (seed == 32'd0) ? 32'd1 : seed;
    assign rst_word  = pattern_word(mode, seed, 32'd0, lfsr_init);
    assign chk_exp   = pattern_word(mode_q, seed_q, chk_idx_q, chk_lfsr_q);

    always_comb begin
        gen_idx_d     = gen_idx_q;
        gen_lfsr_d    = gen_lfsr_q;
        chk_idx_d     = chk_idx_q;
        chk_lfsr_d    = chk_lfsr_q;
        err_d         = err_q;
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        wc_d          = wc_q;
        thr_d         = throttle_set ? throttle_val : {thr_q[30:0], thr_q[31]};
        if (gen_read) begin
            gen_idx_d  = gen_idx_q + 32'd1;
            gen_lfsr_d = lfsr_adv(gen_lfsr_q);
        end
        if (chk_write) begin
            chk_idx_d  = chk_idx_q + 32'd1;
            chk_lfsr_d = lfsr_adv(chk_lfsr_q);
            wc_d       = wc_q + 32'd1;
            if (chk_data != chk_exp) begin
                if (err_q != {ERR_WIDTH{1'b1}}) err_d = err_q + ERR_WIDTH'(1);
                if (!first_valid_q) begin
                    first_valid_d = 1'b1;
                    first_idx_d   = chk_idx_q;
                end
            end
        end
        gen_data_d = pattern_word(mode_q, seed_q, gen_idx_d, gen_lfsr_d);
`ifdef PIPE_PATTERN_INJECT_EN
        inj_d = inj_q | inject_err;
        if (gen_read && inj_d) begin
            gen_data_d[0] = ~gen_data_d[0];
            inj_d         = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q        <= mode;
            seed_q        <= seed;
            gen_idx_q     <= '0;
            gen_lfsr_q    <= lfsr_init;
            gen_data_q    <= rst_word;
            chk_idx_q     <= '0;
            chk_lfsr_q    <= lfsr_init;
            err_q         <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            wc_q          <= '0;
            thr_q         <= 32'hFFFF_FFFF;
`ifdef PIPE_PATTERN_INJECT_EN
            inj_q         <= 1'b0;
`endif
        end else begin
            gen_idx_q     <= gen_idx_d;
            gen_lfsr_q    <= gen_lfsr_d;
            gen_data_q    <= gen_data_d;
            chk_idx_q     <= chk_idx_d;
            chk_lfsr_q    <= chk_lfsr_d;
            err_q         <= err_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            wc_q          <= wc_d;
            thr_q         <= thr_d;
`ifdef PIPE_PATTERN_INJECT_EN
            inj_q         <= inj_d;
`endif
        end
    end

    pipe_pattern_ready_fsm #(.BLOCK_WORDS(BLOCK_WORDS)) u_gen_fsm (
        .clk(clk), .reset_n(reset_n), .grant(thr_q[31]), .strobe(gen_read),
        .ready(gen_ready), .state_dbg(gen_state_dbg)
    );

    pipe_pattern_ready_fsm #(.BLOCK_WORDS(BLOCK_WORDS)) u_chk_fsm (
        .clk(clk), .reset_n(reset_n), .grant(thr_q[31]), .strobe(chk_write),
        .ready(chk_ready), .state_dbg(chk_state_dbg)
    );

    assign gen_data        = gen_data_q;
    assign error_count     = err_q;
    assign first_err_valid = first_valid_q;
    assign first_err_index = first_idx_q;
    assign word_count      = wc_q;
endmodule

// File: tb/tb_pipe_pattern_engine.sv
// Randomized bench for pipe_pattern_engine (64-bit words, 4-word blocks, 4-bit error counter).
module tb_pipe_pattern_engine;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [31:0]   seed = 32'd0;
  logic          throttle_set = 1'b0;
  logic [31:0]   throttle_val = 32'd0;
  logic          gen_read = 1'b0;
  logic [DW-1:0] gen_data;
  logic          gen_ready;
  logic          chk_write = 1'b0;
  logic [DW-1:0] chk_data = '0;
  logic          chk_ready;
  logic [3:0]    error_count;
  logic          first_err_valid;
  logic [31:0]   first_err_index;
  logic [31:0]   word_count;
  logic [1:0]    gen_state_dbg, chk_state_dbg;
`ifdef PIPE_PATTERN_INJECT_EN
  logic          inject_err = 1'b0;
`endif

  pipe_pattern_engine #(.DATA_WIDTH(64), .BLOCK_WORDS(4), .ERR_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .seed(seed),
    .throttle_set(throttle_set), .throttle_val(throttle_val),
    .gen_read(gen_read),
`ifdef PIPE_PATTERN_INJECT_EN
    .inject_err(inject_err),
`endif
    .gen_data(gen_data), .gen_ready(gen_ready),
    .chk_write(chk_write), .chk_data(chk_data), .chk_ready(chk_ready),
    .error_count(error_count), .first_err_valid(first_err_valid),
    .first_err_index(first_err_index), .word_count(word_count),
    .gen_state_dbg(gen_state_dbg), .chk_state_dbg(chk_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: LFSR state sequence plus pattern rules
  logic [2:0]  m_mode;
  logic [31:0] m_seed;
  logic [31:0] lfsr_seq [0:2599];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic build_model(input logic [2:0] m, input logic [31:0] s);
    logic [31:0] st;
    m_mode = m;
    m_seed = s;
    st = (s == 32'd0) ? 32'd1 : s;
    for (int i = 0; i < 2600; i++) begin
      lfsr_seq[i] = st;
      st = {st[30:0], st[31] ^ st[21] ^ st[1] ^ st[0]};
    end
  endtask

  function automatic logic [DW-1:0] model_word(input int n);
    logic [DW-1:0] w;
    int pos;
    w = '0;
    for (int k = 0; k < 2; k++) begin
      pos = n * 2 + k;
      case (m_mode)
        3'd1:    w[32*k +: 32] = lfsr_seq[pos];
        3'd2:    w[32*k +: 32] = 32'd1 << (pos % 32);
        3'd3:    w[32*k +: 32] = m_seed;
        3'd4:    w[32*k +: 32] = (n % 2 == 1) ? ~m_seed : m_seed;
        default: w[32*k +: 32] = 32'(pos);
      endcase
    end
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [2:0] m, input logic [31:0] s);
    reset_n = 1'b0;
    mode = m;
    seed = s;
    gen_read = 1'b0;
    chk_write = 1'b0;
    throttle_set = 1'b0;
    tick();
    reset_n = 1'b1;
    mode = 3'($urandom_range(0, 7));
    seed = $urandom;
    build_model(m, s);
  endtask

  task automatic check_idle_state(input string tag);
    check_eq({tag, "_gen_ready"}, 64'(gen_ready), 64'd0);
    check_eq({tag, "_chk_ready"}, 64'(chk_ready), 64'd0);
    check_eq({tag, "_error_count"}, 64'(error_count), 64'd0);
    check_eq({tag, "_first_err_valid"}, 64'(first_err_valid), 64'd0);
    check_eq({tag, "_first_err_index"}, 64'(first_err_index), 64'd0);
    check_eq({tag, "_word_count"}, 64'(word_count), 64'd0);
    check_eq({tag, "_gen_data"}, gen_data, model_word(0));
  endtask

  int c_idx, g_idx, e_err, e_wc, e_fidx;
  logic e_fv, corrupt;
  logic [63:0] xr;

  initial begin
    tick();
    tick();

    // counter pattern, first three reads, reset state
    do_reset(3'd0, 32'd0);
    check_idle_state("reset");
    check_eq("t1_word0", gen_data, 64'h00000001_00000000);
    for (int n = 1; n <= 3; n++) begin
      gen_read = 1'b1;
      tick();
      gen_read = 1'b0;
      check_eq("t1_word", gen_data, {32'(2 * n + 1), 32'(2 * n)});
    end

    // LFSR loopback, 1024 words
    do_reset(3'd1, 32'd0);
    for (int n = 0; n < 1024; n++) begin
      check_eq("t2_gen_data", gen_data, model_word(n));
      gen_read = 1'b1;
      chk_write = 1'b1;
      chk_data = gen_data;
      tick();
    end
    gen_read = 1'b0;
    chk_write = 1'b0;
    tick();
    check_eq("t2_error_count", 64'(error_count), 64'd0);
    check_eq("t2_word_count", 64'(word_count), 64'd1024);
    check_eq("t2_first_err_valid", 64'(first_err_valid), 64'd0);

    // fixed pattern, corrupt words 5 and 9
    do_reset(3'd3, 32'hA5A5A5A5);
    for (int n = 0; n < 12; n++) begin
      xr = {$urandom, $urandom};
      if (xr == 64'd0) xr = 64'd1;
      chk_write = 1'b1;
      chk_data = model_word(n) ^ ((n == 5 || n == 9) ? xr : 64'd0);
      tick();
    end
    chk_write = 1'b0;
    tick();
    check_eq("t3_error_count", 64'(error_count), 64'd2);
    check_eq("t3_first_err_index", 64'(first_err_index), 64'd5);
    check_eq("t3_first_err_valid", 64'(first_err_valid), 64'd1);
    check_eq("t3_word_count", 64'(word_count), 64'd12);

    // throttle 0x80000000 with continuous reads
    do_reset(3'd0, 32'd0);
    throttle_set = 1'b1;
    throttle_val = 32'h8000_0000;
    gen_read = 1'b1;
    tick();
    throttle_set = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      check_eq("t4_gen_ready", 64'(gen_ready),
               64'((j <= 4) || (j >= 34 && ((j - 34) % 32) < 4)));
      tick();
    end
    gen_read = 1'b0;
    check_eq("t4_chk_ready_no_writes", 64'(chk_ready), 64'd1);

    // saturation of the 4-bit error counter
    do_reset(3'd0, 32'd0);
    for (int n = 0; n < 20; n++) begin
      chk_write = 1'b1;
      chk_data = ~model_word(n);
      tick();
      chk_write = 1'b0;
      tick();
      check_eq("t5_error_count", 64'(error_count), 64'((n + 1 > 15) ? 15 : n + 1));
    end
    check_eq("t5_first_err_index", 64'(first_err_index), 64'd0);
    check_eq("t5_word_count", 64'(word_count), 64'd20);

    // reset mid-block with strobes asserted during reset
    do_reset(3'd0, 32'd0);
    for (int n = 0; n < 3; n++) begin
      gen_read = 1'b1;
      chk_write = 1'b1;
      chk_data = ~model_word(n);
      tick();
    end
    check_eq("t6_gen_ready_mid", 64'(gen_ready), 64'd1);
    check_eq("t6_error_pre", 64'(error_count), 64'd3);
    reset_n = 1'b0;
    mode = 3'd0;
    seed = 32'd0;
    chk_data = {$urandom, $urandom};
    tick();
    check_idle_state("t6_reset");
    reset_n = 1'b1;
    chk_data = model_word(0);
    gen_read = 1'b0;
    tick();
    chk_write = 1'b0;
    tick();
    check_eq("t6_post_errors", 64'(error_count), 64'd0);
    check_eq("t6_post_words", 64'(word_count), 64'd1);

    // randomized modes, seeds and strobe patterns
    for (int it = 0; it < 10; it++) begin
      do_reset(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      check_eq("rnd_gen_data0", gen_data, model_word(0));
      g_idx = 0; c_idx = 0; e_err = 0; e_wc = 0; e_fv = 1'b0; e_fidx = 0;
      for (int cyc = 0; cyc < 150; cyc++) begin
        gen_read = 1'($urandom_range(0, 1));
        chk_write = 1'($urandom_range(0, 1));
        corrupt = ($urandom_range(0, 7) == 0);
        xr = {$urandom, $urandom};
        if (xr == 64'd0) xr = 64'h8000_0000_0000_0000;
        chk_data = model_word(c_idx) ^ (corrupt ? xr : 64'd0);
        if (chk_write) begin
          if (corrupt) begin
            if (e_err < 15) e_err++;
            if (!e_fv) begin
              e_fv = 1'b1;
              e_fidx = c_idx;
            end
          end
          e_wc++;
          c_idx++;
        end
        if (gen_read) g_idx++;
        exp_q.push_back(model_word(g_idx));
        tick();
        check_eq("rnd_gen_data", gen_data, exp_q.pop_front());
        check_eq("rnd_error_count", 64'(error_count), 64'(e_err));
        check_eq("rnd_word_count", 64'(word_count), 64'(e_wc));
      end
      gen_read = 1'b0;
      chk_write = 1'b0;
      check_eq("rnd_first_err_valid", 64'(first_err_valid), 64'(e_fv));
      check_eq("rnd_first_err_index", 64'(first_err_index), 64'(e_fidx));
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
